// File: rtl/pe_pkg.sv
// Shared types and constants for the PE datapath blocks.
package pe_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/subtractor.sv
// 1-bit full-subtractor cell: diff = a - b - c, borrow out when a < b + c.
module subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic borrow_o,
  output logic diff_o
);

  assign diff_o   = a_i ^ b_i ^ c_i;
  assign borrow_o = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - borrow_i, one bit per clock, LSB first,
// reusing a single full-subtractor cell with valid/ready on both sides.
module serial_subtractor
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cell_diff;
  logic             cell_borrow;

  subtractor u_cell (
    .a_i      (a_q[0]),
    .b_i      (b_q[0]),
    .c_i      (borrow_q),
    .borrow_o (cell_borrow),
    .diff_o   (cell_diff)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath: result fills from the MSB so bit 0 lands last at [0].
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = borrow_i;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        res_d    = (res_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
        borrow_d = cell_borrow;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign diff_o   = res_q;
  assign borrow_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed/random and WIDTH=1 exhaustive.
module tb_serial_subtractor;

  localparam int unsigned W  = 8;
  localparam int unsigned W1 = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i, ready_o, ready_i, borrow_i, valid_o, borrow_o;
  logic [W-1:0] a_i, b_i, diff_o;
  logic         v1_i, r1_o, a1_i, b1_i, bi1_i, v1_o, rdy1_i, d1_o, bo1_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W:0] exp_q[$];
  int         lat_q[$];
  logic [1:0] exp1_q[$];
  int         lat1_q[$];

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .borrow_i(borrow_i), .valid_o(valid_o),
    .ready_i(ready_i), .diff_o(diff_o), .borrow_o(borrow_o)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1_i), .ready_o(r1_o),
    .a_i(a1_i), .b_i(b1_i), .borrow_i(bi1_i), .valid_o(v1_o),
    .ready_i(rdy1_i), .diff_o(d1_o), .borrow_o(bo1_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - W1'(bin);
  endfunction

  // Monitor: pops expectations whenever a result transfers; checks valid_o latency on rise.
  initial begin : monitor
    bit prev_v  = 1'b0;
    bit prev_v1 = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (valid_o && !prev_v) begin
        if (lat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL lat8: unexpected valid_o at cycle %0d", cyc);
        end else chk("lat8", 32'(cyc - lat_q.pop_front()), 32'(W));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res8: unexpected result 0x%0h at cycle %0d", {borrow_o, diff_o}, cyc);
        end else chk("res8", 32'({borrow_o, diff_o}), 32'(exp_q.pop_front()));
      end
      if (v1_o && !prev_v1) begin
        if (lat1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL lat1: unexpected valid_o at cycle %0d", cyc);
        end else chk("lat1", 32'(cyc - lat1_q.pop_front()), 32'd1);
      end
      if (v1_o && rdy1_i) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res1: unexpected result at cycle %0d", cyc);
        end else chk("res1", 32'({bo1_o, d1_o}), 32'(exp1_q.pop_front()));
      end
      prev_v  = valid_o;
      prev_v1 = v1_o;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input int gap, input bit rnd);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    a_i = a; b_i = b; borrow_i = bin; valid_i = 1'b1;
    n = 0;
    while (!ready_o) begin
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout: ready_o stuck 0 at cycle %0d", cyc);
        valid_i = 1'b0;
        return;
      end
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    exp_q.push_back(model(a, b, bin));
    lat_q.push_back(cyc + 1);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Wait for the result transfer, scrambling operand inputs to prove they are not re-sampled.
  task automatic drain(input bit rnd);
    int n = 0;
    do begin
      a_i = W'($urandom); b_i = W'($urandom); borrow_i = 1'($urandom);
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end while (!ready_o && n < 300);
    if (!ready_o) begin
      checks++; errors++;
      $display("FAIL drain_timeout: ready_o stuck 0 at cycle %0d", cyc);
    end
  endtask

  task automatic send1(input logic a, input logic b, input logic bin);
    int n;
    @(negedge clk);
    a1_i = a; b1_i = b; bi1_i = bin; v1_i = 1'b1;
    exp1_q.push_back(2'({1'b0, a} - {1'b0, b} - {1'b0, bin}));
    lat1_q.push_back(cyc + 1);
    @(negedge clk);
    v1_i = 1'b0;
    for (n = 0; !r1_o && n < 10; n++) @(negedge clk);
    chk("w1_idle", 32'(r1_o), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0; borrow_i = 1'b0;
    v1_i = 1'b0; rdy1_i = 1'b1; a1_i = 1'b0; b1_i = 1'b0; bi1_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_diff", 32'(diff_o), 32'd0);
    chk("rst_borrow", 32'(borrow_o), 32'd0);
    chk("rst_ready1", 32'(r1_o), 32'd1);
    rst = 1'b0;

    // Basic subtraction and single-cycle valid pulse
    send(8'h5A, 8'h23, 1'b0, 0, 1'b0);
    for (n = 0; !valid_o && n < 20; n++) @(negedge clk);
    chk("basic_diff", 32'(diff_o), 32'h37);
    chk("basic_borrow", 32'(borrow_o), 32'd0);
    @(negedge clk);
    chk("basic_pulse", 32'(valid_o), 32'd0);
    drain(1'b0);

    // Underflow and other directed vectors
    send(8'h00, 8'h01, 1'b0, 0, 1'b0); drain(1'b0);
    send(8'hFF, 8'hFF, 1'b1, 0, 1'b0); drain(1'b0);
    send(8'h80, 8'h7F, 1'b0, 1, 1'b0); drain(1'b0);
    send(8'h00, 8'h00, 1'b1, 0, 1'b0); drain(1'b0);
    send(8'hFF, 8'h00, 1'b0, 2, 1'b0); drain(1'b0);

    // Backpressure: result held, no accept while in DONE
    ready_i = 1'b0;
    send(8'hC3, 8'h3C, 1'b0, 0, 1'b0);
    for (n = 0; !valid_o && n < 20; n++) @(negedge clk);
    chk("bp_valid_rise", 32'(valid_o), 32'd1);
    valid_i = 1'b1; a_i = 8'h11; b_i = 8'h22; borrow_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_diff", 32'(diff_o), 32'h87);
      chk("bp_hold_borrow", 32'(borrow_o), 32'd0);
      chk("bp_hold_valid", 32'(valid_o), 32'd1);
      chk("bp_no_ready", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    send(8'h11, 8'h22, 1'b1, 0, 1'b0);
    drain(1'b0);

    // Reset during SHIFT bit 3, then accept on the first edge after release
    @(negedge clk);
    a_i = 8'hA5; b_i = 8'h12; borrow_i = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    chk("mid_rst_diff", 32'(diff_o), 32'd0);
    chk("mid_rst_borrow", 32'(borrow_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    a_i = 8'h10; b_i = 8'h01; borrow_i = 1'b0; valid_i = 1'b1;
    exp_q.push_back(model(8'h10, 8'h01, 1'b0));
    lat_q.push_back(cyc + 1);
    @(negedge clk);
    valid_i = 1'b0;
    drain(1'b0);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      send1(v[2], v[1], v[0]);
    end

    // Random operations with valid/ready gaps
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
      drain(1'b1);
    end
    ready_i = 1'b1;

    repeat (3) @(negedge clk);
    chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("end_exp1_empty", 32'(exp1_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
